dec3t8_grant: RTL and testbench



---
 rtl/dec3t8_grant.sv | 162 ++++++++++++++++
 tb/tb_dec3t8_grant.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dec3t8_grant.sv
// rtl/dec3t8_grant.sv - sequential 3-to-8 grant decoder with ack/timeout release handshake
//
// Purpose: accepts an encoded request index from the priority encoder, drives a
// registered one-hot grant to the selected source and holds it until the source
// acknowledges (then waits for ack to fall) or until TIMEOUT grant cycles expire.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     encoded request present this cycle
//   in_code[2:0] encoded index of highest-priority requester
//   in_idle      encoder idle flag (1 = no active request)
//   in_ready     block can accept a request (combinational, state IDLE)
//   ack          acknowledge from the granted source
//   grant[7:0]   registered one-hot grant
//   busy         registered, 1 when not IDLE
//   done         one-cycle pulse on normal completion
//   timeout_err  one-cycle pulse on timeout abort
//   grant_cnt    (DEC3T8_STATS_EN only) saturating count of done pulses
//   to_cnt       (DEC3T8_STATS_EN only) saturating count of timeout_err pulses
//
// Optional feature macro: DEC3T8_STATS_EN

module dec3t8_grant #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    input  logic       in_idle,
    output logic       in_ready,
    input  logic       ack,
    output logic [7:0] grant,
    output logic       busy,
    output logic       done,
`ifdef DEC3T8_STATS_EN
    output logic [7:0] grant_cnt,
    output logic [7:0] to_cnt,
`endif
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [2:0]      code_q, code_d;
    logic [7:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            terr_q, terr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= 3'd0;
            grant_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        terr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // ack in IDLE is ignored; in_code is don't-care while in_idle=1.
                if (in_valid && !in_idle) begin
                    code_d  = in_code;
                    cnt_d   = '0;
                    grant_d = 8'h01 << in_code;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // ack is checked before the timeout so a same-cycle ack wins.
                if (ack) begin
                    grant_d = 8'h00;
                    state_d = S_RELEASE;
                end else if (cnt_q + 1'b1 == TO_LIMIT) begin
                    // This was the TIMEOUT-th grant cycle without ack.
                    cnt_d   = TO_LIMIT;
                    grant_d = 8'h00;
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                grant_d = 8'h00;
                if (!ack) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = 8'h00;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign in_ready    = (state_q == S_IDLE);
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

`ifdef DEC3T8_STATS_EN
    logic [7:0] gcnt_q, gcnt_d;
    logic [7:0] tcnt_q, tcnt_d;

    // Counters advance with the same next-state pulses so they line up with done/timeout_err.
    always_comb begin
        gcnt_d = gcnt_q;
        tcnt_d = tcnt_q;
        if (done_d && gcnt_q != 8'hFF) gcnt_d = gcnt_q + 8'd1;
        if (terr_d && tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q <= 8'h00;
            tcnt_q <= 8'h00;
        end else begin
            gcnt_q <= gcnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign grant_cnt = gcnt_q;
    assign to_cnt    = tcnt_q;
`endif

endmodule

// File: tb/tb_dec3t8_grant.sv
// tb/tb_dec3t8_grant.sv - directed self-checking bench for dec3t8_grant
module tb_dec3t8_grant;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_idle;
    logic       in_ready;
    logic       ack;
    logic [7:0] grant;
    logic       busy;
    logic       done;
    logic       timeout_err;
`ifdef DEC3T8_STATS_EN
    logic [7:0] grant_cnt;
    logic [7:0] to_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dec3t8_grant #(.TIMEOUT(15), .TO_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_code     (in_code),
        .in_idle     (in_idle),
        .in_ready    (in_ready),
        .ack         (ack),
        .grant       (grant),
        .busy        (busy),
        .done        (done),
`ifdef DEC3T8_STATS_EN
        .grant_cnt   (grant_cnt),
        .to_cnt      (to_cnt),
`endif
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full clock: inputs and checks both live on the falling edge.
    task automatic tick();
        @(negedge clk);
        chk("onehot", {7'd0, ($countones(grant) <= 1)}, 8'h01);
    endtask

    task automatic req(input logic [2:0] code);
        in_valid = 1'b1;
        in_idle  = 1'b0;
        in_code  = code;
        tick();
        in_valid = 1'b0;
        in_code  = 3'd0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_grant"}, grant, 8'h00);
        chk({tag, "_busy"}, {7'd0, busy}, 8'h00);
        chk({tag, "_rdy"}, {7'd0, in_ready}, 8'h01);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_code = 3'd0; in_idle = 1'b1; ack = 1'b0;
        tick(); tick();
        chk_idle_outs("rst");
        chk("rst_done", {7'd0, done}, 8'h00);
        chk("rst_terr", {7'd0, timeout_err}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Basic grant on code 5, ack on third grant cycle
        req(3'd5);
        chk("b_grant", grant, 8'h20);
        chk("b_busy", {7'd0, busy}, 8'h01);
        chk("b_rdy", {7'd0, in_ready}, 8'h00);
        in_code = 3'd1;                 // ignored while granting
        tick(); tick();
        chk("b_hold", grant, 8'h20);
        ack = 1'b1;
        tick();
        chk("b_rel_grant", grant, 8'h00);
        chk("b_rel_busy", {7'd0, busy}, 8'h01);
        chk("b_rel_done", {7'd0, done}, 8'h00);
        tick();
        chk("b_rel_wait", {7'd0, done}, 8'h00);
        ack = 1'b0;
        tick();
        chk("b_done", {7'd0, done}, 8'h01);
        chk_idle_outs("b_end");
        tick();
        chk("b_done_pulse", {7'd0, done}, 8'h00);

        // Idle filter
        in_valid = 1'b1; in_idle = 1'b1; in_code = 3'd7;
        tick();
        chk_idle_outs("if");
        req(3'd0);
        chk("if_grant0", grant, 8'h01);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("if_done", {7'd0, done}, 8'h01);

        // Timeout on code 2: grant lasts exactly 15 cycles
        req(3'd2);
        chk("to_g1", grant, 8'h04);
        for (int i = 2; i <= 15; i++) begin
            tick();
            chk("to_hold", grant, 8'h04);
            chk("to_noerr", {7'd0, timeout_err}, 8'h00);
        end
        tick();
        chk("to_terr", {7'd0, timeout_err}, 8'h01);
        chk("to_done", {7'd0, done}, 8'h00);
        chk_idle_outs("to_end");
        tick();
        chk("to_pulse", {7'd0, timeout_err}, 8'h00);

        // Ack on the 15th grant cycle beats the timeout
        req(3'd3);
        for (int i = 2; i <= 15; i++) tick();
        chk("col_g15", grant, 8'h08);
        ack = 1'b1;
        tick();
        chk("col_grant", grant, 8'h00);
        chk("col_terr", {7'd0, timeout_err}, 8'h00);
        chk("col_busy", {7'd0, busy}, 8'h01);
        ack = 1'b0;
        tick();
        chk("col_done", {7'd0, done}, 8'h01);
        chk("col_terr2", {7'd0, timeout_err}, 8'h00);

        // Early ack: held high in IDLE, grant lasts one cycle
        ack = 1'b1;
        tick();
        chk_idle_outs("ea_idle");
        req(3'd6);
        chk("ea_g1", grant, 8'h40);
        tick();
        chk("ea_g2", grant, 8'h00);
        ack = 1'b0;
        tick();
        chk("ea_done", {7'd0, done}, 8'h01);

        // Asynchronous reset mid-grant
        req(3'd7);
        chk("ar_grant", grant, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outs("ar");
        chk("ar_done", {7'd0, done}, 8'h00);
        chk("ar_terr", {7'd0, timeout_err}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_after_done", {7'd0, done}, 8'h00);

        // Back-to-back: new request accepted on each done cycle
        req(3'd1);
        chk("bb_g1", grant, 8'h02);
        ack = 1'b1; tick();
        ack = 1'b0; in_valid = 1'b1; in_idle = 1'b0; in_code = 3'd4;
        tick();
        chk("bb_done1", {7'd0, done}, 8'h01);
        chk("bb_rdy1", {7'd0, in_ready}, 8'h01);
        tick();
        chk("bb_g4", grant, 8'h10);
        in_valid = 1'b0;
        ack = 1'b1; tick();
        ack = 1'b0; in_valid = 1'b1; in_code = 3'd6;
        tick();
        chk("bb_done2", {7'd0, done}, 8'h01);
        tick();
        chk("bb_g6", grant, 8'h40);
        in_valid = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("bb_done3", {7'd0, done}, 8'h01);
        req(3'd0);
        for (int i = 2; i <= 16; i++) tick();
        chk("bb_terr", {7'd0, timeout_err}, 8'h01);
`ifdef DEC3T8_STATS_EN
        chk("st_grant_cnt", grant_cnt, 8'd3);
        chk("st_to_cnt", to_cnt, 8'd1);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
